// File: rtl/ray_pkg.sv
// Shared types and defaults for the ray-marcher output path.
package ray_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam int AXIS_DATA_W = 32;
  localparam int IMG_W_DEF   = 640;
  localparam int IMG_H_DEF   = 480;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of rgb888_t. The head comes straight from the storage registers,
// so there is no combinational path from push to dout.
module pixel_fifo
  import ray_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  rgb888_t       din,
  input  logic          pop,
  output rgb888_t       dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  rgb888_t       mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/shade_axis_writer.sv
// Shader-to-DMA bridge: buffers shaded pixels and emits them as an AXI4-Stream video
// stream, tracking raster position internally to generate tuser/tlast.
module shade_axis_writer
  import ray_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_WIDTH  = 24
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [OUT_WIDTH-1:0]   pixel_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   frame_done,
  output logic                   overflow
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rgb888_t       fifo_din, fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          unused_full;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          rst_done_q, frame_done_q, overflow_q;
  logic          hs, x_last, y_last;

  assign fifo_din    = pixel_in;
  assign unused_full = fifo_full;

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (valid_in && ready_out),
    .din   (fifo_din),
    .pop   (hs),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // rst_done_q holds ready_out low during reset even though the count is already zero.
  assign ready_out     = rst_done_q && (fifo_count < CW'(FIFO_DEPTH));
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : {{(AXIS_DATA_W-24){1'b0}}, fifo_dout};
  assign hs            = m_axis_tvalid && m_axis_tready;

  assign x_last        = (x_q == XW'(IMG_W - 1));
  assign y_last        = (y_q == YW'(IMG_H - 1));
  assign m_axis_tuser  = m_axis_tvalid && (x_q == '0) && (y_q == '0);
  assign m_axis_tlast  = m_axis_tvalid && x_last;
  assign frame_done    = frame_done_q;
  assign overflow      = overflow_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (hs) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      x_q          <= '0;
      y_q          <= '0;
      rst_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      rst_done_q   <= 1'b1;
      frame_done_q <= hs && x_last && y_last;
      overflow_q   <= overflow_q || (valid_in && !ready_out);
    end
  end

endmodule

// File: tb/tb_shade_axis_writer.sv
// Directed bench for shade_axis_writer with a queue-based reference model checked every cycle.
module tb_shade_axis_writer;
  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 4;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [23:0] pixel_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        frame_done;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  shade_axis_writer #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D), .OUT_WIDTH(24)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .pixel_in      (pixel_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .frame_done    (frame_done),
    .overflow      (overflow)
  );

  always #5 aclk = ~aclk;

  // Reference model: accepted pixels in a queue, position as a beat index within the frame.
  logic [23:0] mq[$];
  int          mbeat = 0;
  bit          movf  = 0;
  bit          mfd   = 0;
  bit          minit = 0;
  bit          chk_en = 0;

  logic [31:0] lg_d[$];
  bit          lg_u[$];
  bit          lg_l[$];
  int          fd_cnt = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Inputs change just after posedge, so at negedge both outputs and next-edge inputs are stable.
  always @(negedge aclk) begin
    bit sz, m_ready, pop, push;
    sz = (mq.size() > 0);
    if (chk_en) begin
      cmp("ready_out", {31'b0, ready_out}, {31'b0, minit && (mq.size() < D)});
      cmp("tvalid",    {31'b0, m_axis_tvalid}, {31'b0, sz});
      cmp("tdata",     m_axis_tdata, sz ? {8'h00, mq[0]} : 32'h0);
      cmp("tuser",     {31'b0, m_axis_tuser}, {31'b0, sz && (mbeat == 0)});
      cmp("tlast",     {31'b0, m_axis_tlast}, {31'b0, sz && (mbeat % W == W - 1)});
      cmp("frame_done",{31'b0, frame_done}, {31'b0, mfd});
      cmp("overflow",  {31'b0, overflow}, {31'b0, movf});
    end
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      lg_d.push_back(m_axis_tdata);
      lg_u.push_back(m_axis_tuser);
      lg_l.push_back(m_axis_tlast);
    end
    if (frame_done === 1'b1) fd_cnt++;
    if (!aresetn) begin
      mq.delete();
      mbeat = 0; movf = 0; mfd = 0; minit = 0;
    end else begin
      m_ready = minit && (mq.size() < D);
      pop     = sz && m_axis_tready;
      push    = valid_in && m_ready;
      mfd     = pop && (mbeat == W * H - 1);
      if (pop) begin
        void'(mq.pop_front());
        mbeat = (mbeat + 1) % (W * H);
      end
      if (push) mq.push_back(pixel_in);
      if (valid_in && !m_ready) movf = 1;
      minit = 1;
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [23:0] p, input bit r);
    valid_in = v; pixel_in = p; m_axis_tready = r;
    step();
  endtask

  task automatic clr_log();
    lg_d.delete(); lg_u.delete(); lg_l.delete();
    fd_cnt = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    cmp({tag, "_ready"},  {31'b0, ready_out}, 32'h0);
    cmp({tag, "_tvalid"}, {31'b0, m_axis_tvalid}, 32'h0);
    cmp({tag, "_tdata"},  m_axis_tdata, 32'h0);
    cmp({tag, "_tuser"},  {31'b0, m_axis_tuser}, 32'h0);
    cmp({tag, "_tlast"},  {31'b0, m_axis_tlast}, 32'h0);
    cmp({tag, "_fdone"},  {31'b0, frame_done}, 32'h0);
    cmp({tag, "_ovf"},    {31'b0, overflow}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] exp2 [4];
    int sent;
    bit v;
    exp2[0] = 32'h00AA0000; exp2[1] = 32'h0000BB00;
    exp2[2] = 32'h000000CC; exp2[3] = 32'h00112233;

    aresetn = 1'b0; valid_in = 1'b0; pixel_in = '0; m_axis_tready = 1'b0;
    step();
    chk_en = 1;
    step();
    chk_reset_outputs("rst0");
    aresetn = 1'b1;
    step();
    cmp("ready_after_rst", {31'b0, ready_out}, 32'h1);

    // 1: full frame back-to-back
    clr_log();
    for (int i = 1; i <= 8; i++) drive(1'b1, 24'(i), 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 24'h0, 1'b1);
    cmp("t1_beats", lg_d.size(), 8);
    for (int i = 0; i < 8 && i < lg_d.size(); i++) begin
      cmp("t1_data", lg_d[i], 32'(i + 1));
      cmp("t1_user", {31'b0, lg_u[i]}, {31'b0, i == 0});
      cmp("t1_last", {31'b0, lg_l[i]}, {31'b0, i == 3 || i == 7});
    end
    cmp("t1_fdone", fd_cnt, 1);

    // 2: fill under backpressure
    clr_log();
    drive(1'b1, 24'hAA0000, 1'b0);
    drive(1'b1, 24'h00BB00, 1'b0);
    drive(1'b1, 24'h0000CC, 1'b0);
    drive(1'b1, 24'h112233, 1'b0);
    cmp("t2_ready_full", {31'b0, ready_out}, 32'h0);
    cmp("t2_head", m_axis_tdata, 32'h00AA0000);
    drive(1'b0, 24'h0, 1'b0);
    drive(1'b0, 24'h0, 1'b0);
    cmp("t2_head_hold", m_axis_tdata, 32'h00AA0000);

    // 3: overflow while full
    drive(1'b1, 24'hFFFFFF, 1'b0);
    drive(1'b1, 24'hFFFFFF, 1'b0);
    cmp("t3_ovf", {31'b0, overflow}, 32'h1);
    drive(1'b0, 24'h0, 1'b0);
    cmp("t3_ovf_sticky", {31'b0, overflow}, 32'h1);
    cmp("t3_head", m_axis_tdata, 32'h00AA0000);

    // 4: full with pop and push offered in the same cycle
    cmp("t4_ready_pre", {31'b0, ready_out}, 32'h0);
    drive(1'b1, 24'h445566, 1'b1);
    cmp("t4_ready_post", {31'b0, ready_out}, 32'h1);
    drive(1'b0, 24'h0, 1'b0);
    cmp("t4_head", m_axis_tdata, 32'h0000BB00);
    for (int i = 0; i < 5; i++) drive(1'b0, 24'h0, 1'b1);
    cmp("t4_beats", lg_d.size(), 4);
    for (int i = 0; i < 4 && i < lg_d.size(); i++) begin
      cmp("t4_data", lg_d[i], exp2[i]);
      cmp("t4_user", {31'b0, lg_u[i]}, {31'b0, i == 0});
      cmp("t4_last", {31'b0, lg_l[i]}, {31'b0, i == 3});
    end

    // 5: reset mid-frame (raster sits at beat 4, start of line 1)
    clr_log();
    drive(1'b1, 24'h000021, 1'b1);
    drive(1'b1, 24'h000022, 1'b1);
    drive(1'b1, 24'h000023, 1'b1);
    drive(1'b0, 24'h0, 1'b1);
    cmp("t5_beats", lg_d.size(), 3);
    for (int i = 0; i < 3 && i < lg_d.size(); i++) begin
      cmp("t5_user", {31'b0, lg_u[i]}, 32'h0);
      cmp("t5_last", {31'b0, lg_l[i]}, 32'h0);
    end
    aresetn = 1'b0;
    drive(1'b0, 24'h0, 1'b1);
    chk_reset_outputs("t5_rst");
    aresetn = 1'b1;
    drive(1'b0, 24'h0, 1'b1);
    clr_log();
    drive(1'b1, 24'h000031, 1'b1);
    drive(1'b0, 24'h0, 1'b1);
    drive(1'b0, 24'h0, 1'b1);
    cmp("t5_post_beats", lg_d.size(), 1);
    if (lg_d.size() > 0) begin
      cmp("t5_post_data", lg_d[0], 32'h00000031);
      cmp("t5_post_user", {31'b0, lg_u[0]}, 32'h1);
    end

    // 6: two frames with tready toggling every cycle
    aresetn = 1'b0;
    drive(1'b0, 24'h0, 1'b0);
    aresetn = 1'b1;
    drive(1'b0, 24'h0, 1'b0);
    clr_log();
    sent = 0;
    for (int c = 0; c < 200 && !(sent == 16 && lg_d.size() == 16); c++) begin
      v = (sent < 16) && ready_out;
      drive(v, 24'(32'h100 + sent), c[0]);
      if (v) sent++;
    end
    drive(1'b0, 24'h0, 1'b0);
    drive(1'b0, 24'h0, 1'b0);
    cmp("t6_beats", lg_d.size(), 16);
    for (int i = 0; i < 16 && i < lg_d.size(); i++) begin
      cmp("t6_data", lg_d[i], 32'h100 + 32'(i));
      cmp("t6_user", {31'b0, lg_u[i]}, {31'b0, i == 0 || i == 8});
      cmp("t6_last", {31'b0, lg_l[i]}, {31'b0, (i % 4) == 3});
    end
    cmp("t6_fdone", fd_cnt, 2);
    cmp("t6_ovf", {31'b0, overflow}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
